// File: rtl/vivado_demo.sv
// Bring-up counter: waits a fixed lock time after reset, then counts while enabled.
// The count advances by STEP once every PRESCALE enabled cycles in RUN.
module vivado_demo #(
    parameter int unsigned LOCK_CYCLES = 8,
    parameter int unsigned PRESCALE    = 1,
    parameter logic [7:0]  STEP        = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] out
);

    localparam int unsigned TimerW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [TimerW-1:0] LockLast = TimerW'(LOCK_CYCLES - 1);
    localparam logic [PreW-1:0]   PreLast  = PreW'(PRESCALE - 1);
    localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
    localparam logic [PreW-1:0]   PreOne   = PreW'(1);

    typedef enum logic [1:0] {
        StWaitLock,
        StIdle,
        StRun
    } state_e;

    state_e            state;
    logic [TimerW-1:0] lock_timer;
    logic [PreW-1:0]   prescaler;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StWaitLock;
            lock_timer <= '0;
            prescaler  <= '0;
            out        <= '0;
        end else begin
            unique case (state)
                // Timer stops at LOCK_CYCLES once lock is reached, so it never toggles again.
                StWaitLock: begin
                    lock_timer <= lock_timer + TimerOne;
                    if (lock_timer == LockLast) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (enable) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        state <= StIdle;
                    end else if (prescaler == PreLast) begin
                        prescaler <= '0;
                        out       <= out + STEP;
                    end else begin
                        prescaler <= prescaler + PreOne;
                    end
                end
                default: begin
                    state <= StWaitLock;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vivado_demo.sv
// Scoreboard bench for vivado_demo: two parameterisations driven by shared stimulus,
// expected counts derived from elapsed lock time and number of enabled RUN cycles.
module tb_vivado_demo;

    localparam int unsigned LockA = 8;
    localparam int unsigned PreA  = 1;
    localparam int unsigned StepA = 1;
    localparam int unsigned LockB = 5;
    localparam int unsigned PreB  = 4;
    localparam int unsigned StepB = 3;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] out_a;
    logic [7:0] out_b;

    int checks;
    int errors;

    vivado_demo #(
        .LOCK_CYCLES(LockA),
        .PRESCALE   (PreA),
        .STEP       (8'(StepA))
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .out   (out_a)
    );

    vivado_demo #(
        .LOCK_CYCLES(LockB),
        .PRESCALE   (PreB),
        .STEP       (8'(StepB))
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .out   (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, edges since reset, whether RUN holds before the
    // edge, and number of enabled RUN cycles; out = STEP * floor(n / PRESCALE) mod 256.
    int          since    [2];
    int          n_run    [2];
    bit          in_run   [2];
    int unsigned lock_p   [2];
    int unsigned pre_p    [2];
    int unsigned step_p   [2];
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic [7:0]  last_a;

    function automatic logic [7:0] model_edge(input int i, input bit rst, input bit en);
        bit locked;
        if (rst) begin
            since[i]  = 0;
            n_run[i]  = 0;
            in_run[i] = 1'b0;
        end else begin
            locked = (since[i] >= int'(lock_p[i]));
            if (in_run[i] && en) n_run[i]++;
            in_run[i] = locked && en;
            since[i]++;
        end
        return 8'((int'(step_p[i]) * (n_run[i] / int'(pre_p[i]))) % 256);
    endfunction

    task automatic cycle(input bit rst, input bit en);
        logic [7:0] ea;
        logic [7:0] eb;
        @(negedge clk);
        reset  = rst;
        enable = en;
        @(posedge clk);
        ea = model_edge(0, rst, en);
        eb = model_edge(1, rst, en);
        q_a.push_back(ea);
        q_b.push_back(eb);
        last_a = ea;
    endtask

    // Monitor: out is registered, so sample it mid-cycle against the queued expectation.
    always @(negedge clk) begin
        logic [7:0] exp_v;
        if (q_a.size() > 0) begin
            exp_v = q_a.pop_front();
            checks++;
            if (out_a !== exp_v) begin
                errors++;
                $display("FAIL out_a at %0t: got %0d expected %0d", $time, out_a, exp_v);
            end
        end
        if (q_b.size() > 0) begin
            exp_v = q_b.pop_front();
            checks++;
            if (out_b !== exp_v) begin
                errors++;
                $display("FAIL out_b at %0t: got %0d expected %0d", $time, out_b, exp_v);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        last_a    = '0;
        lock_p[0] = LockA; pre_p[0] = PreA; step_p[0] = StepA;
        lock_p[1] = LockB; pre_p[1] = PreB; step_p[1] = StepB;
        reset     = 1'b1;
        enable    = 1'b1;

        // Reset held with enable high.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);

        // Lock wait with enable high from the start, then steady counting.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);

        // Count up to 20, pause 5 cycles, resume.
        for (int i = 0; i < 300 && last_a != 8'd20; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);

        // Long run across the 255 -> 0 wrap.
        for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1);

        // Mid-run reset at 100, relock, resume.
        for (int i = 0; i < 300 && last_a != 8'd100; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1);

        // Enable asserted during lock wait, dropped before lock, raised after.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

        // Random enable with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
